// File: rtl/id_pipe_buf.sv
// Decode-to-execute buffer: DEPTH-entry circular FIFO of decoded bundles with
// valid/ready handshakes, synchronous flush and an exception fence.
module id_pipe_buf #(
  parameter int PC_W   = 30,
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_exp_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_exp_code,
  output logic [CNT_W-1:0]  count,
  output logic              fence
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + DATA_W + 3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             fence_r;

  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] head_s;
  logic [2:0]       head_exp_s;

  assign out_valid  = (count_r != {CNT_W{1'b0}});
  assign in_ready   = (count_r != FULL_CNT) & ~fence_r;
  assign push_s     = in_valid & in_ready & ~flush;
  assign pop_s      = out_valid & out_ready & ~flush;
  assign head_s     = mem_r[rd_ptr_r];
  assign head_exp_s = head_s[2:0];
  assign count      = count_r;
  assign fence      = fence_r;

  // Head presentation; an empty buffer drives an all-zero NOP bubble.
  always_comb begin
    out_pc       = {PC_W{1'b0}};
    out_data     = {DATA_W{1'b0}};
    out_exp_code = 3'd0;
    if (out_valid) begin
      out_pc       = head_s[ENT_W-1 -: PC_W];
      out_data     = head_s[DATA_W+2 -: DATA_W];
      out_exp_code = head_exp_s;
    end else begin
      out_pc       = {PC_W{1'b0}};
      out_data     = {DATA_W{1'b0}};
      out_exp_code = 3'd0;
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_pc, in_data, in_exp_code};
    end
  end

  // Pointers, occupancy and fence; flush discards any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      fence_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      fence_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // The excepting bundle is always the youngest, so a set never races its own clear.
      if (push_s && (in_exp_code != 3'd0)) begin
        fence_r <= 1'b1;
      end else if (pop_s && (head_exp_s != 3'd0)) begin
        fence_r <= 1'b0;
      end else begin
        fence_r <= fence_r;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe_buf.sv
// Directed bench for id_pipe_buf: a DEPTH=2 instance driven from a vector table
// plus hand sequences, and a DEPTH=4/DATA_W=128 instance for fill/drain order.
module tb_id_pipe_buf;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  // DEPTH=2 instance
  logic        flush, in_valid, in_ready, out_valid, out_ready, fence;
  logic [29:0] in_pc, out_pc;
  logic [95:0] in_data, out_data;
  logic [2:0]  in_exp_code, out_exp_code;
  logic [1:0]  count;

  // DEPTH=4, DATA_W=128 instance
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fence;
  logic [29:0]  b_in_pc, b_out_pc;
  logic [127:0] b_in_data, b_out_data;
  logic [2:0]   b_in_exp_code, b_out_exp_code;
  logic [2:0]   b_count;

  id_pipe_buf u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_exp_code(in_exp_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_exp_code(out_exp_code),
    .count(count), .fence(fence)
  );

  id_pipe_buf #(.PC_W(30), .DATA_W(128), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_data(b_in_data),
    .in_exp_code(b_in_exp_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_data(b_out_data), .out_exp_code(b_out_exp_code),
    .count(b_count), .fence(b_fence)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [29:0] ipc;
    logic [2:0]  iexp;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        erdy;
    logic [29:0] epc;
    logic [2:0]  eexp;
    logic [1:0]  ecnt;
    logic        efence;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  function automatic logic [95:0] data_of(input logic [29:0] pc);
    return {pc ^ 30'h2AAA_AAAA, 2'b01, {2'b00, pc} * 32'd7, ~{2'b00, pc}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input vec_t v);
    chk({tag, " out_valid"}, 128'(out_valid), 128'(v.ev));
    chk({tag, " in_ready"},  128'(in_ready),  128'(v.erdy));
    chk({tag, " out_pc"},    128'(out_pc),    128'(v.epc));
    chk({tag, " out_exp"},   128'(out_exp_code), 128'(v.eexp));
    chk({tag, " count"},     128'(count),     128'(v.ecnt));
    chk({tag, " fence"},     128'(fence),     128'(v.efence));
    chk({tag, " out_data"},  128'(out_data),  v.ev ? 128'(data_of(v.epc)) : 128'd0);
  endtask

  logic [127:0] q [4];
  vec_t         vx;

  initial begin
    n_checks = 0;
    n_errors = 0;
    //            iv    ipc        iexp  ordy  fl    ev    erdy  epc        eexp  ecnt  efence
    vt[0]  = '{1'b1, 30'h10,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h10,  3'd0, 2'd1, 1'b0};
    vt[1]  = '{1'b1, 30'h11,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h10,  3'd0, 2'd2, 1'b0};
    vt[2]  = '{1'b1, 30'h12,  3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 30'h11,  3'd0, 2'd1, 1'b0};
    vt[3]  = '{1'b0, 30'h0,   3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};
    vt[4]  = '{1'b1, 30'h100, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 30'h100, 3'd0, 2'd1, 1'b0};
    for (int k = 1; k <= 7; k++) begin
      vt[4+k] = '{1'b1, 30'h100 + 30'(k), 3'd0, 1'b1, 1'b0,
                  1'b1, 1'b1, 30'h100 + 30'(k), 3'd0, 2'd1, 1'b0};
    end
    vt[12] = '{1'b0, 30'h0,   3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};
    vt[13] = '{1'b1, 30'h30,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h30,  3'd0, 2'd1, 1'b0};
    vt[14] = '{1'b1, 30'h20,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 30'h30,  3'd0, 2'd2, 1'b1};
    vt[15] = '{1'b1, 30'h21,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h20,  3'd3, 2'd1, 1'b1};
    vt[16] = '{1'b1, 30'h21,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h20,  3'd3, 2'd1, 1'b1};
    vt[17] = '{1'b1, 30'h21,  3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};
    vt[18] = '{1'b1, 30'h21,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h21,  3'd0, 2'd1, 1'b0};
    vt[19] = '{1'b1, 30'h22,  3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 30'h22,  3'd5, 2'd1, 1'b1};
    vt[20] = '{1'b0, 30'h0,   3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};
    vt[21] = '{1'b1, 30'h40,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h40,  3'd0, 2'd1, 1'b0};
    vt[22] = '{1'b1, 30'h41,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h40,  3'd0, 2'd2, 1'b0};
    vt[23] = '{1'b1, 30'h42,  3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};
    vt[24] = '{1'b1, 30'h43,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h43,  3'd0, 2'd1, 1'b0};
    vt[25] = '{1'b0, 30'h0,   3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h0,   3'd0, 2'd0, 1'b0};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 30'd0; in_data = 96'd0; in_exp_code = 3'd0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_pc = 30'd0; b_in_data = 128'd0; b_in_exp_code = 3'd0;
    step(); step();
    reset = 1'b1;
    step();
    vx = '{1'b0, 30'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 3'd0, 2'd0, 1'b0};
    chk_state("reset", vx);

    // Table-driven main sequence: drive, clock, compare the post-edge state.
    for (int i = 0; i < NV; i++) begin
      in_valid    = vt[i].iv;
      in_pc       = vt[i].ipc;
      in_data     = data_of(vt[i].ipc);
      in_exp_code = vt[i].iexp;
      out_ready   = vt[i].ordy;
      flush       = vt[i].fl;
      if (i == 0) begin
        #1;
        chk("no_bypass out_valid", 128'(out_valid), 128'd0);
      end
      step();
      chk_state($sformatf("vec%0d", i), vt[i]);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // Asynchronous reset with two bundles buffered and the fence up.
    in_valid = 1'b1; in_pc = 30'h50; in_data = data_of(30'h50); in_exp_code = 3'd0;
    step();
    in_pc = 30'h51; in_data = data_of(30'h51); in_exp_code = 3'd1;
    step();
    in_valid = 1'b0; in_exp_code = 3'd0;
    chk("pre_rst count", 128'(count), 128'd2);
    chk("pre_rst fence", 128'(fence), 128'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst count",     128'(count),     128'd0);
    chk("async_rst out_valid", 128'(out_valid), 128'd0);
    chk("async_rst fence",     128'(fence),     128'd0);
    chk("async_rst out_data",  128'(out_data),  128'd0);
    #1;
    reset = 1'b1;
    step();
    chk("post_rst in_ready", 128'(in_ready), 128'd1);
    chk("post_rst count",    128'(count),    128'd0);

    // Wider/deeper build: fill to full, then drain and compare bit-exact order.
    for (int i = 0; i < 4; i++) begin
      q[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_pc   = 30'h200 + 30'(i);
      b_in_data = q[i];
      step();
      chk($sformatf("d4 fill count%0d", i), 128'(b_count), 128'(i + 1));
    end
    b_in_pc = 30'h2FF; b_in_data = 128'd0;
    chk("d4 full in_ready", 128'(b_in_ready), 128'd0);
    step();
    chk("d4 full hold count", 128'(b_count), 128'd4);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d4 drain data%0d", i), b_out_data, q[i]);
      chk($sformatf("d4 drain pc%0d", i), 128'(b_out_pc), 128'(30'h200 + 30'(i)));
      step();
    end
    b_out_ready = 1'b0;
    chk("d4 empty count",     128'(b_count),     128'd0);
    chk("d4 empty out_valid", 128'(b_out_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
